feistel_iter_core: RTL



---
 rtl/feistel_iter_core.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/feistel_iter_core.sv
// Iterative Feistel cipher engine: one round per clock, encrypt or decrypt
// selected per block, valid/ready handshakes on both sides. Round keys are
// fetched from an external key schedule through rk_idx/rk_in.
module feistel_iter_core #(
    parameter int                HALF_W  = 32,
    parameter int                ROUNDS  = 16,
    parameter int                ROT     = 1,
    parameter logic [HALF_W-1:0] F_CONST = 32'h5A5A5A5A,
    parameter int                IDX_W   = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2*HALF_W-1:0]       in_data,
    input  logic                      in_decrypt,
    output logic [IDX_W-1:0]          rk_idx,
    input  logic [3*HALF_W/2-1:0]     rk_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*HALF_W-1:0]       out_data,
    output logic                      busy
);

    localparam int H     = HALF_W / 2;
    localparam int KEY_W = 3 * H;

    // Counter value of the final round; the counter never goes past it.
    localparam logic [IDX_W-1:0] LAST = IDX_W'(ROUNDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  cnt;
    logic              mode_dec;
    logic [HALF_W-1:0] half_l;
    logic [HALF_W-1:0] half_r;
    logic [HALF_W-1:0] f_out;
    logic [HALF_W-1:0] r_next;

    // Left rotate by ROT; ROT of zero is passed straight through so the
    // complementary right shift never needs a full-width shift amount.
    function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] v);
        if (ROT == 0) begin
            return v;
        end
        return (v << ROT) | (v >> (HALF_W - ROT));
    endfunction

    // Round function: expand R to 3H bits by repeating its upper half, mix
    // in the key, fold the top H bits back onto both halves, then rotate
    // and whiten with the constant.
    function automatic logic [HALF_W-1:0] round_f(
        input logic [HALF_W-1:0] r,
        input logic [KEY_W-1:0]  k
    );
        logic [KEY_W-1:0]  e;
        logic [KEY_W-1:0]  x;
        logic [HALF_W-1:0] c;
        e = {r[HALF_W-1:H], r};
        x = e ^ k;
        c = x[HALF_W-1:0] ^ {x[KEY_W-1:HALF_W], x[KEY_W-1:HALF_W]};
        return rotl(c) ^ F_CONST;
    endfunction

    // Round datapath evaluated on the current halves and the key fetched
    // for this cycle.
    always_comb begin
        f_out  = round_f(half_r, rk_in);
        r_next = half_l ^ f_out;
    end

    // Control FSM plus block registers; every output is registered so the
    // key index is stable for the whole cycle the key schedule decodes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mode_dec  <= 1'b0;
            half_l    <= '0;
            half_r    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            rk_idx    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        half_l   <= in_data[2*HALF_W-1:HALF_W];
                        half_r   <= in_data[HALF_W-1:0];
                        mode_dec <= in_decrypt;
                        cnt      <= '0;
                        // Decrypt walks the key schedule backwards.
                        rk_idx   <= in_decrypt ? LAST : '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_RUN;
                    end
                end

                S_RUN: begin
                    half_l <= half_r;
                    half_r <= r_next;
                    if (cnt == LAST) begin
                        // Final swap folded into the output register.
                        out_data  <= {r_next, half_r};
                        out_valid <= 1'b1;
                        rk_idx    <= '0;
                        state     <= S_DONE;
                    end else begin
                        cnt    <= cnt + 1'b1;
                        rk_idx <= mode_dec ? (LAST - cnt - 1'b1) : (cnt + 1'b1);
                    end
                end

                S_DONE: begin
                    // Only the output handshake is serviced here; a waiting
                    // input block is taken once back in IDLE.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        cnt       <= '0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    rk_idx    <= '0;
                end
            endcase
        end
    end

endmodule
